// File: rtl/snax_tcdm_stream_adapter.sv
// Streamer-to-TCDM adapter: per-port request FIFOs, bounded outstanding reads,
// registered read responses, sticky error flag and a drain-aware barrier.
module snax_tcdm_stream_adapter #(
    parameter int unsigned NumPorts       = 24,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned AddrWidth      = 48,
    parameter int unsigned FifoDepth      = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter logic [4:0]  CoreId         = 5'd0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumPorts-1:0]               acc_req_valid_i,
    output logic [NumPorts-1:0]               acc_req_ready_o,
    input  logic [NumPorts-1:0]               acc_req_write_i,
    input  logic [NumPorts*AddrWidth-1:0]     acc_req_addr_i,
    input  logic [NumPorts*DataWidth-1:0]     acc_req_data_i,
    input  logic [NumPorts*(DataWidth/8)-1:0] acc_req_strb_i,
    output logic [NumPorts-1:0]               acc_rsp_valid_o,
    output logic [NumPorts*DataWidth-1:0]     acc_rsp_data_o,
    output logic [NumPorts-1:0]               tcdm_req_valid_o,
    input  logic [NumPorts-1:0]               tcdm_req_ready_i,
    output logic [NumPorts-1:0]               tcdm_req_write_o,
    output logic [NumPorts*AddrWidth-1:0]     tcdm_req_addr_o,
    output logic [NumPorts*DataWidth-1:0]     tcdm_req_data_o,
    output logic [NumPorts*(DataWidth/8)-1:0] tcdm_req_strb_o,
    output logic [NumPorts*4-1:0]             tcdm_req_amo_o,
    output logic [NumPorts*5-1:0]             tcdm_req_core_id_o,
    output logic [NumPorts-1:0]               tcdm_req_is_core_o,
    input  logic [NumPorts-1:0]               tcdm_rsp_valid_i,
    input  logic [NumPorts*DataWidth-1:0]     tcdm_rsp_data_i,
    input  logic                              csr_idle_i,
    output logic                              barrier_o,
    output logic                              err_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned PtrWidth  = $clog2(FifoDepth);
    localparam int unsigned CntWidth  = $clog2(FifoDepth + 1);
    localparam int unsigned OutWidth  = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] DepthVal  = CntWidth'(FifoDepth);
    localparam logic [OutWidth-1:0] MaxOutVal = OutWidth'(MaxOutstanding);

    typedef struct packed {
        logic                 write;
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
    } entry_t;

    entry_t                    mem_q    [NumPorts][FifoDepth];
    entry_t                    mem_d    [NumPorts][FifoDepth];
    logic [PtrWidth-1:0]       wr_ptr_q [NumPorts];
    logic [PtrWidth-1:0]       wr_ptr_d [NumPorts];
    logic [PtrWidth-1:0]       rd_ptr_q [NumPorts];
    logic [PtrWidth-1:0]       rd_ptr_d [NumPorts];
    logic [CntWidth-1:0]       cnt_q    [NumPorts];
    logic [CntWidth-1:0]       cnt_d    [NumPorts];
    logic [OutWidth-1:0]       outst_q  [NumPorts];
    logic [OutWidth-1:0]       outst_d  [NumPorts];
    logic [NumPorts-1:0]           rsp_valid_q, rsp_valid_d;
    logic [NumPorts*DataWidth-1:0] rsp_data_q, rsp_data_d;
    logic                          err_q, err_d;
    logic                          barrier_q, barrier_d;

    entry_t head, in_entry;
    logic   push, pop, rd_hs, rsp, any_busy;

    assign tcdm_req_amo_o     = '0;
    assign tcdm_req_core_id_o = {NumPorts{CoreId}};
    assign tcdm_req_is_core_o = '0;
    assign acc_rsp_valid_o    = rsp_valid_q;
    assign acc_rsp_data_o     = rsp_data_q;
    assign err_o              = err_q;
    assign barrier_o          = barrier_q;

    // Per-port FIFO, issue gating, outstanding tracking and barrier condition.
    always_comb begin
        mem_d            = mem_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        cnt_d            = cnt_q;
        outst_d          = outst_q;
        rsp_valid_d      = tcdm_rsp_valid_i;
        rsp_data_d       = rsp_data_q;
        err_d            = err_q;
        acc_req_ready_o  = '0;
        tcdm_req_valid_o = '0;
        tcdm_req_write_o = '0;
        tcdm_req_addr_o  = '0;
        tcdm_req_data_o  = '0;
        tcdm_req_strb_o  = '0;
        head             = '0;
        in_entry         = '0;
        push             = 1'b0;
        pop              = 1'b0;
        rd_hs            = 1'b0;
        rsp              = 1'b0;
        any_busy         = 1'b0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            head           = mem_q[p][rd_ptr_q[p]];
            in_entry.write = acc_req_write_i[p];
            in_entry.addr  = acc_req_addr_i[p*AddrWidth +: AddrWidth];
            in_entry.data  = acc_req_data_i[p*DataWidth +: DataWidth];
            in_entry.strb  = acc_req_strb_i[p*StrbWidth +: StrbWidth];

            acc_req_ready_o[p]  = (cnt_q[p] != DepthVal);
            tcdm_req_valid_o[p] = (cnt_q[p] != '0) && (head.write || (outst_q[p] < MaxOutVal));
            tcdm_req_write_o[p] = head.write;
            tcdm_req_addr_o[p*AddrWidth +: AddrWidth] = head.addr;
            tcdm_req_data_o[p*DataWidth +: DataWidth] = head.data;
            tcdm_req_strb_o[p*StrbWidth +: StrbWidth] = head.strb;

            push  = acc_req_valid_i[p] && acc_req_ready_o[p];
            pop   = tcdm_req_valid_o[p] && tcdm_req_ready_i[p];
            rd_hs = pop && !head.write;
            rsp   = tcdm_rsp_valid_i[p];

            if (push) begin
                mem_d[p][wr_ptr_q[p]] = in_entry;
                wr_ptr_d[p]           = wr_ptr_q[p] + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr_d[p] = rd_ptr_q[p] + PtrWidth'(1);
            end
            cnt_d[p] = cnt_q[p] + CntWidth'(push) - CntWidth'(pop);

            if (rsp && (outst_q[p] == '0)) begin
                err_d = 1'b1;
            end
            if (rd_hs && !rsp) begin
                outst_d[p] = outst_q[p] + OutWidth'(1);
            end else if (!rd_hs && rsp && (outst_q[p] != '0)) begin
                outst_d[p] = outst_q[p] - OutWidth'(1);
            end

            if (rsp) begin
                rsp_data_d[p*DataWidth +: DataWidth] = tcdm_rsp_data_i[p*DataWidth +: DataWidth];
            end
            // A push this cycle also counts as busy so the barrier drops one cycle after it.
            if (push || (cnt_q[p] != '0) || (outst_q[p] != '0) || rsp) begin
                any_busy = 1'b1;
            end
        end
        barrier_d = csr_idle_i && !any_busy;
    end

    // FIFO storage; contents are qualified by the occupancy count, so no reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned p = 0; p < NumPorts; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                cnt_q[p]    <= '0;
                outst_q[p]  <= '0;
            end
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            barrier_q   <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            outst_q     <= outst_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
            barrier_q   <= barrier_d;
        end
    end

endmodule

// File: tb/tb_snax_tcdm_stream_adapter.sv
// Scoreboard bench for snax_tcdm_stream_adapter: directed stimulus pushes
// expected TCDM requests/responses; a negedge monitor pops and compares.
module tb_snax_tcdm_stream_adapter;

    localparam int unsigned NP = 24;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 48;
    localparam int unsigned SW = 8;
    localparam logic [4:0]  CID = 5'd7;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     acc_req_valid_i, acc_req_ready_o, acc_req_write_i;
    logic [NP*AW-1:0]  acc_req_addr_i;
    logic [NP*DW-1:0]  acc_req_data_i;
    logic [NP*SW-1:0]  acc_req_strb_i;
    logic [NP-1:0]     acc_rsp_valid_o;
    logic [NP*DW-1:0]  acc_rsp_data_o;
    logic [NP-1:0]     tcdm_req_valid_o, tcdm_req_ready_i, tcdm_req_write_o;
    logic [NP*AW-1:0]  tcdm_req_addr_o;
    logic [NP*DW-1:0]  tcdm_req_data_o;
    logic [NP*SW-1:0]  tcdm_req_strb_o;
    logic [NP*4-1:0]   tcdm_req_amo_o;
    logic [NP*5-1:0]   tcdm_req_core_id_o;
    logic [NP-1:0]     tcdm_req_is_core_o;
    logic [NP-1:0]     tcdm_rsp_valid_i;
    logic [NP*DW-1:0]  tcdm_rsp_data_i;
    logic              csr_idle_i, barrier_o, err_o;

    always #5 clk = ~clk;

    snax_tcdm_stream_adapter #(
        .NumPorts(NP), .DataWidth(DW), .AddrWidth(AW),
        .FifoDepth(2), .MaxOutstanding(4), .CoreId(CID)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .acc_req_valid_i(acc_req_valid_i), .acc_req_ready_o(acc_req_ready_o),
        .acc_req_write_i(acc_req_write_i), .acc_req_addr_i(acc_req_addr_i),
        .acc_req_data_i(acc_req_data_i), .acc_req_strb_i(acc_req_strb_i),
        .acc_rsp_valid_o(acc_rsp_valid_o), .acc_rsp_data_o(acc_rsp_data_o),
        .tcdm_req_valid_o(tcdm_req_valid_o), .tcdm_req_ready_i(tcdm_req_ready_i),
        .tcdm_req_write_o(tcdm_req_write_o), .tcdm_req_addr_o(tcdm_req_addr_o),
        .tcdm_req_data_o(tcdm_req_data_o), .tcdm_req_strb_o(tcdm_req_strb_o),
        .tcdm_req_amo_o(tcdm_req_amo_o), .tcdm_req_core_id_o(tcdm_req_core_id_o),
        .tcdm_req_is_core_o(tcdm_req_is_core_o),
        .tcdm_rsp_valid_i(tcdm_rsp_valid_i), .tcdm_rsp_data_i(tcdm_rsp_data_i),
        .csr_idle_i(csr_idle_i), .barrier_o(barrier_o), .err_o(err_o)
    );

    typedef struct {
        int          port;
        logic        write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } req_t;
    typedef struct {
        int          port;
        logic [DW-1:0] data;
    } rsp_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];
    int   hs_count[NP];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request on port p and wait (bounded) for it to be accepted; valid is left high.
    task automatic send(input int p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [SW-1:0] s, output int waited);
        req_t e;
        bit   done;
        acc_req_valid_i[p] = 1'b1;
        acc_req_write_i[p] = w;
        acc_req_addr_i[p*AW +: AW] = a;
        acc_req_data_i[p*DW +: DW] = d;
        acc_req_strb_i[p*SW +: SW] = s;
        waited = 0;
        done   = 1'b0;
        while (!done && waited < 20) begin
            @(negedge clk);
            if (acc_req_ready_o[p]) begin
                e.port = p; e.write = w; e.addr = a; e.data = d; e.strb = s;
                exp_req.push_back(e);
                done = 1'b1;
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout port=%0d actual=not_accepted required=accepted", p);
        end
    endtask

    task automatic respond(input int p, input logic [DW-1:0] d);
        rsp_t r;
        tcdm_rsp_valid_i[p] = 1'b1;
        tcdm_rsp_data_i[p*DW +: DW] = d;
        r.port = p;
        r.data = d;
        exp_rsp.push_back(r);
        tick();
        tcdm_rsp_valid_i[p] = 1'b0;
    endtask

    // Monitor: every TCDM handshake and every accelerator response is checked against the queues.
    always @(negedge clk) begin : monitor
        int   idx;
        req_t e;
        rsp_t r;
        if (!rst) begin
            for (int p = 0; p < NP; p++) begin
                if (tcdm_req_valid_o[p] && tcdm_req_ready_i[p]) begin
                    hs_count[p]++;
                    idx = -1;
                    for (int i = 0; i < exp_req.size(); i++)
                        if (idx < 0 && exp_req[i].port == p) idx = i;
                    if (idx < 0) begin
                        checks++;
                        errors++;
                        $display("FAIL req_unexpected port=%0d actual=issue required=none", p);
                    end else begin
                        e = exp_req[idx];
                        exp_req.delete(idx);
                        chk("req_write", 64'(tcdm_req_write_o[p]), 64'(e.write));
                        chk("req_addr", 64'(tcdm_req_addr_o[p*AW +: AW]), 64'(e.addr));
                        chk("req_data", tcdm_req_data_o[p*DW +: DW], e.data);
                        chk("req_strb", 64'(tcdm_req_strb_o[p*SW +: SW]), 64'(e.strb));
                        chk("req_amo", 64'(tcdm_req_amo_o[p*4 +: 4]), 64'd0);
                        chk("req_core_id", 64'(tcdm_req_core_id_o[p*5 +: 5]), 64'(CID));
                        chk("req_is_core", 64'(tcdm_req_is_core_o[p]), 64'd0);
                    end
                end
                if (acc_rsp_valid_o[p]) begin
                    idx = -1;
                    for (int i = 0; i < exp_rsp.size(); i++)
                        if (idx < 0 && exp_rsp[i].port == p) idx = i;
                    if (idx < 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected port=%0d actual=valid required=none", p);
                    end else begin
                        r = exp_rsp[idx];
                        exp_rsp.delete(idx);
                        chk("rsp_data", acc_rsp_data_o[p*DW +: DW], r.data);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stim
        int w;
        for (int p = 0; p < NP; p++) hs_count[p] = 0;
        rst              = 1'b1;
        acc_req_valid_i  = '0;
        acc_req_write_i  = '0;
        acc_req_addr_i   = '0;
        acc_req_data_i   = '0;
        acc_req_strb_i   = '0;
        tcdm_req_ready_i = '1;
        tcdm_rsp_valid_i = '0;
        tcdm_rsp_data_i  = '0;
        csr_idle_i       = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset / idle state
        @(negedge clk);
        chk("rst_barrier", 64'(barrier_o), 64'd1);
        chk("rst_ready", 64'(acc_req_ready_o), 64'(24'hFFFFFF));
        chk("rst_tcdm_valid", 64'(tcdm_req_valid_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_rsp_valid", 64'(acc_rsp_valid_o), 64'd0);

        // Port 0 write: one-cycle accept-to-issue, barrier dips and recovers
        tick();
        send(0, 1'b1, 48'h100, 64'hDEAD, 8'hFF, w);
        acc_req_valid_i[0] = 1'b0;
        @(negedge clk);
        chk("wr_issue_latency", 64'(tcdm_req_valid_o[0]), 64'd1);
        chk("wr_barrier_low", 64'(barrier_o), 64'd0);
        repeat (3) tick();
        @(negedge clk);
        chk("wr_barrier_back", 64'(barrier_o), 64'd1);
        chk("wr_valid_done", 64'(tcdm_req_valid_o[0]), 64'd0);

        // Port 3: five reads, only four may be outstanding
        tick();
        for (int i = 0; i < 5; i++) send(3, 1'b0, 48'h300 + 48'(i * 8), 64'd0, 8'h00, w);
        acc_req_valid_i[3] = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rd_issued_four", 64'(hs_count[3]), 64'd4);
        chk("rd_fifth_blocked", 64'(tcdm_req_valid_o[3]), 64'd0);
        respond(3, 64'h1234);
        @(negedge clk);
        chk("rd_fifth_issues", 64'(tcdm_req_valid_o[3]), 64'd1);
        chk("rd_rsp_valid", 64'(acc_rsp_valid_o[3]), 64'd1);
        chk("rd_rsp_data", acc_rsp_data_o[3*DW +: DW], 64'h1234);
        tick();
        @(negedge clk);
        chk("rd_issued_five", 64'(hs_count[3]), 64'd5);
        chk("rd_rsp_data_hold", acc_rsp_data_o[3*DW +: DW], 64'h1234);
        for (int i = 0; i < 4; i++) respond(3, 64'hA0 + 64'(i));

        // Port 1: backpressure fills the FIFO, then drains in order
        tcdm_req_ready_i[1] = 1'b0;
        send(1, 1'b1, 48'h1000, 64'hA, 8'hFF, w);
        send(1, 1'b1, 48'h1008, 64'hB, 8'h0F, w);
        acc_req_addr_i[1*AW +: AW] = 48'h1010;
        acc_req_data_i[1*DW +: DW] = 64'hC;
        acc_req_strb_i[1*SW +: SW] = 8'h33;
        @(negedge clk);
        chk("bp_ready_low", 64'(acc_req_ready_o[1]), 64'd0);
        chk("bp_valid_held", 64'(tcdm_req_valid_o[1]), 64'd1);
        tick();
        tcdm_req_ready_i[1] = 1'b1;
        send(1, 1'b1, 48'h1010, 64'hC, 8'h33, w);
        chk("bp_ready_after_pop", 64'(w), 64'd1);
        acc_req_valid_i[1] = 1'b0;
        repeat (4) tick();

        // Port 2: response with nothing outstanding
        respond(2, 64'h55);
        @(negedge clk);
        chk("err_set", 64'(err_o), 64'd1);
        repeat (3) tick();
        @(negedge clk);
        chk("err_sticky", 64'(err_o), 64'd1);
        chk("err_counter_zero_barrier", 64'(barrier_o), 64'd1);

        // Barrier follows csr_idle_i
        csr_idle_i = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("csr_busy_barrier", 64'(barrier_o), 64'd0);
        tick();
        csr_idle_i = 1'b1;
        @(negedge clk);
        chk("csr_idle_barrier_hold", 64'(barrier_o), 64'd0);
        @(negedge clk);
        chk("csr_idle_barrier_rise", 64'(barrier_o), 64'd1);

        // Port 4: three reads in flight, two queued, then reset mid-stream
        tick();
        for (int i = 0; i < 3; i++) send(4, 1'b0, 48'h400 + 48'(i * 8), 64'd0, 8'h00, w);
        acc_req_valid_i[4] = 1'b0;
        repeat (2) tick();
        tcdm_req_ready_i[4] = 1'b0;
        for (int i = 3; i < 5; i++) send(4, 1'b0, 48'h400 + 48'(i * 8), 64'd0, 8'h00, w);
        acc_req_valid_i[4] = 1'b0;
        @(negedge clk);
        chk("mid_issued_three", 64'(hs_count[4]), 64'd3);
        chk("mid_fifo_full", 64'(acc_req_ready_o[4]), 64'd0);
        chk("mid_barrier_low", 64'(barrier_o), 64'd0);
        tick();
        rst = 1'b1;
        for (int i = exp_req.size() - 1; i >= 0; i--)
            if (exp_req[i].port == 4) exp_req.delete(i);
        #2;
        chk("arst_valid", 64'(tcdm_req_valid_o), 64'd0);
        chk("arst_ready", 64'(acc_req_ready_o), 64'(24'hFFFFFF));
        chk("arst_barrier", 64'(barrier_o), 64'd1);
        chk("arst_err", 64'(err_o), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        tcdm_req_ready_i[4] = 1'b1;
        @(negedge clk);
        chk("post_rst_barrier", 64'(barrier_o), 64'd1);
        chk("post_rst_valid", 64'(tcdm_req_valid_o[4]), 64'd0);
        respond(4, 64'h77);
        @(negedge clk);
        chk("post_rst_count_cleared", 64'(err_o), 64'd1);

        tick();
        chk("scoreboard_req_empty", 64'(exp_req.size()), 64'd0);
        chk("scoreboard_rsp_empty", 64'(exp_rsp.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
